lab1_imul_prod_accum: RTL and testbench
=======================================

# lab1_imul_prod_accum

Product accumulator that sits directly downstream of the integer multiplier. It consumes the multiplier's 32-bit product stream over a val/rdy interface and sums each consecutive group of `p_nprods` products. It emits one 32-bit sum per group on a val/rdy output stream, which gives the lab a dot-product / MAC path without touching the multiplier.

## Interface
Parameters:
- `p_nbits`, 32, width of products and of the sum.
- `p_nprods`, 4, products per group; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low. State clears immediately when `reset`=0, independent of `clk`.
- `istream_val`  in  1  a product is offered.
- `istream_rdy`  out  1  block accepts a product this cycle.
- `istream_msg`  in  `p_nbits`  product; connects to the multiplier's `ostream_msg`.
- `ostream_val`  out  1  group sum is valid.
- `ostream_rdy`  in  1  consumer accepts the sum.
- `ostream_msg`  out  `p_nbits`  group sum.

## Operation
- State: FSM {ACC, DONE}, accumulator `acc[p_nbits-1:0]`, counter `cnt[$clog2(p_nprods+1)-1:0]`.
- Transfers:
  - An input transfer is `istream_val && istream_rdy`.
  - An output transfer is `ostream_val && ostream_rdy`.
- ACC state:
  - `istream_rdy`=1, `ostream_val`=0.
  - On an input transfer: `acc <= acc + istream_msg`, `cnt <= cnt + 1`.
  - If that transfer is product number `p_nprods` (`cnt == p_nprods-1`), go to DONE.
- DONE state:
  - `ostream_val`=1, `ostream_msg`=`acc`.
  - `istream_rdy` = `ostream_rdy`. This is a combinational path from ready to ready and is intended.
- DONE, output transfer without an input transfer: `acc <= 0`, `cnt <= 0`, go to ACC.
- DONE, output and input transfer in the same cycle (overlap):
  - `acc <= istream_msg`, `cnt <= 1`.
  - If `p_nprods`==1, stay in DONE. Otherwise go to ACC.
- DONE with `ostream_rdy`=0: `acc`, `cnt` and state hold, `ostream_msg` stays stable, and no input is accepted.
- Arithmetic is modulo 2^`p_nbits`. Overflow wraps silently, with no flag and no saturation.
- `ostream_msg` is driven by `acc` in all states. Its value is meaningful only while `ostream_val`=1.

## Timing
- While `reset`=0: state=ACC, `acc`=0, `cnt`=0, `istream_rdy`=0, `ostream_val`=0, `ostream_msg`=0.
  - `istream_rdy` is gated off during reset.
  - In the first cycle after release, `istream_rdy`=1.
- Latency: the last product of a group is accepted at edge t, and `ostream_val`=1 with the final sum from cycle t onward. That is one cycle after the product was presented.
- Throughput: with `istream_val` and `ostream_rdy` held at 1, the block accepts one product every cycle and never deasserts `istream_rdy`. It emits one sum every `p_nprods` cycles.
- Backpressure: a DONE that is stalled holds for any number of cycles. No product is dropped or double-counted.
- Reset mid-group or mid-DONE: the partial or pending sum is discarded. The next group starts from `acc`=0 and `cnt`=0.
- `istream_val` and `ostream_rdy` may toggle on any cycle. The block never depends on `istream_msg` when `istream_val`=0.

## Structure
- Shared package `lab1_imul_prod_accum_pkg` holds:
  - the state enum (`STATE_ACC`, `STATE_DONE`);
  - the counter-width function/constant derived from `p_nprods`.
- Split into two sub-modules, in the same split as the multiplier:
  - `lab1_imul_prod_accum_dpath`: `acc` register with a 2:1 load mux (clear/load vs. add), adder, `cnt` register, and the `cnt == p_nprods-1` status output.
  - `lab1_imul_prod_accum_ctrl`: FSM and handshake logic.
- The top level connects the two and provides a line trace: input val/rdy/msg, then `acc`, `cnt`, state letter (A/D), then output val/rdy/msg.

## Test plan
All scenarios use `p_nprods`=4 unless stated.
- Basic group: feed 1,2,3,4 back-to-back with `ostream_rdy`=1 -> a single output 0x0000000a, `ostream_val` high for exactly one cycle, starting the cycle after the 4th accept.
- Wrap: feed 0xffffffff, 0x2, 0x0, 0x0 -> 0x00000001.
- Backpressure: feed 5,5,5,5 and hold `ostream_rdy`=0 for 5 cycles after `ostream_val` rises, with `istream_val`=1 presenting 9 -> `ostream_val` and `ostream_msg`=0x14 held, `istream_rdy`=0 throughout. When `ostream_rdy` rises, 0x14 transfers and 9 is accepted in the same cycle as the first product of the next group.
- Overlap streaming: feed 1..8 continuously with `ostream_rdy`=1 -> all 8 accepted in 8 consecutive cycles, `istream_rdy` never low, outputs 0x0a then 0x1a.
- Reset mid-group: accept 5,6, drive `reset`=0 asynchronously mid-cycle -> `istream_rdy` and `ostream_val` drop immediately. After release, feed 1,1,1,1 -> 0x4.
- `p_nprods`=1: stream 7,9 with `ostream_rdy`=1 -> outputs 7 then 9 on consecutive cycles, with `ostream_val` continuously high while input flows.

Source files
------------

// File: rtl/lab1_imul_prod_accum_pkg.sv
// Shared types and helpers for the product accumulator.
//   state_t   : control FSM encoding (ACC accumulating, DONE holding a group sum)
//   cnt_width : width of the per-group product counter for a given group size
package lab1_imul_prod_accum_pkg;

   typedef enum logic {
      STATE_ACC  = 1'b0,
      STATE_DONE = 1'b1
   } state_t;

   // Counter must hold values 0..nprods, hence nprods+1 codes.
   function automatic int unsigned cnt_width(input int unsigned nprods);
      return $clog2(nprods + 1);
   endfunction

endpackage

// File: rtl/lab1_imul_prod_accum_ctrl.sv
// Control: ACC/DONE FSM and val/rdy handshakes.
//   clk, reset   : clock, async active-low reset
//   istream_val  : product offered
//   istream_rdy  : product accepted this cycle (follows ostream_rdy in DONE)
//   ostream_val  : group sum valid
//   ostream_rdy  : consumer takes the sum
//   cnt_last     : next accepted product completes the group
//   acc_en, acc_clr, msg_en : datapath controls
//   state        : current FSM state (for tracing)
module lab1_imul_prod_accum_ctrl
   import lab1_imul_prod_accum_pkg::*;
#(
   parameter int unsigned p_nprods = 4
)(
   input  logic   clk,
   input  logic   reset,
   input  logic   istream_val,
   output logic   istream_rdy,
   output logic   ostream_val,
   input  logic   ostream_rdy,
   input  logic   cnt_last,
   output logic   acc_en,
   output logic   acc_clr,
   output logic   msg_en,
   output state_t state
);

   localparam bit SINGLE = (p_nprods == 1);

   state_t state_next;
   logic   in_go;
   logic   out_go;

   // Handshakes; in DONE a new product may enter only when the sum leaves.
   assign istream_rdy = reset && ((state == STATE_ACC) || ostream_rdy);
   assign ostream_val = reset && (state == STATE_DONE);
   assign in_go       = istream_val && istream_rdy;
   assign out_go      = ostream_val && ostream_rdy;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= STATE_ACC;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         STATE_ACC:  if (in_go && cnt_last) state_next = STATE_DONE;
         STATE_DONE: if (out_go) state_next = (in_go && SINGLE) ? STATE_DONE : STATE_ACC;
         default:    state_next = STATE_ACC;
      endcase
   end

   // Datapath controls; leaving DONE restarts from zero, plus the overlapping product if any.
   always_comb begin
      acc_en  = 1'b0;
      acc_clr = 1'b0;
      msg_en  = 1'b0;
      case (state)
         STATE_ACC: begin
            acc_en = in_go;
            msg_en = in_go;
         end
         STATE_DONE: begin
            acc_en  = out_go;
            acc_clr = 1'b1;
            msg_en  = in_go;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lab1_imul_prod_accum_dpath.sv
// Datapath: accumulator and product counter with a shared clear/load mux.
//   clk, reset   : clock, async active-low reset
//   acc_en       : update acc/cnt this cycle
//   acc_clr      : select zero instead of the current acc/cnt as the adder base
//   msg_en       : add the incoming product (and count it)
//   istream_msg  : incoming product
//   acc, cnt     : registered accumulator and counter
//   cnt_last     : the next accepted product completes the group
module lab1_imul_prod_accum_dpath
   import lab1_imul_prod_accum_pkg::*;
#(
   parameter int unsigned p_nbits  = 32,
   parameter int unsigned p_nprods = 4,
   localparam int unsigned CW      = cnt_width(p_nprods)
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               acc_en,
   input  logic               acc_clr,
   input  logic               msg_en,
   input  logic [p_nbits-1:0] istream_msg,
   output logic [p_nbits-1:0] acc,
   output logic [CW-1:0]      cnt,
   output logic               cnt_last
);

   logic [p_nbits-1:0] acc_base;
   logic [p_nbits-1:0] acc_next;
   logic [CW-1:0]      cnt_base;
   logic [CW-1:0]      cnt_next;

   // Base mux (clear vs. keep) followed by the adder; wraps modulo 2^p_nbits.
   always_comb begin
      acc_base = acc_clr ? '0 : acc;
      cnt_base = acc_clr ? '0 : cnt;
      acc_next = acc_base + (msg_en ? istream_msg : '0);
      cnt_next = cnt_base + CW'(msg_en);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (acc_en) begin
         acc <= acc_next;
         cnt <= cnt_next;
      end
   end

   assign cnt_last = (cnt == CW'(p_nprods - 1));

endmodule

// File: rtl/lab1_imul_prod_accum.sv
// Product accumulator: sums each group of p_nprods products from the
// multiplier and emits one sum per group.
//   clk, reset               : clock, async active-low reset
//   istream_val/rdy/msg      : product stream in
//   ostream_val/rdy/msg      : group-sum stream out (msg mirrors acc at all times)
module lab1_imul_prod_accum
   import lab1_imul_prod_accum_pkg::*;
#(
   parameter int unsigned p_nbits  = 32,
   parameter int unsigned p_nprods = 4
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               istream_val,
   output logic               istream_rdy,
   input  logic [p_nbits-1:0] istream_msg,
   output logic               ostream_val,
   input  logic               ostream_rdy,
   output logic [p_nbits-1:0] ostream_msg
);

   localparam int unsigned CW = cnt_width(p_nprods);

   logic               acc_en;
   logic               acc_clr;
   logic               msg_en;
   logic               cnt_last;
   logic [p_nbits-1:0] acc;
   logic [CW-1:0]      cnt;
   state_t             state;

   lab1_imul_prod_accum_ctrl #(
      .p_nprods (p_nprods)
   ) ctrl (
      .clk         (clk),
      .reset       (reset),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .cnt_last    (cnt_last),
      .acc_en      (acc_en),
      .acc_clr     (acc_clr),
      .msg_en      (msg_en),
      .state       (state)
   );

   lab1_imul_prod_accum_dpath #(
      .p_nbits  (p_nbits),
      .p_nprods (p_nprods)
   ) dpath (
      .clk         (clk),
      .reset       (reset),
      .acc_en      (acc_en),
      .acc_clr     (acc_clr),
      .msg_en      (msg_en),
      .istream_msg (istream_msg),
      .acc         (acc),
      .cnt         (cnt),
      .cnt_last    (cnt_last)
   );

   assign ostream_msg = acc;

   // Line trace: in val/rdy:msg | acc cnt state | out val/rdy:msg
   function automatic string line_trace();
      return $sformatf("%b%b:%h | %h %0d %s | %b%b:%h",
                       istream_val, istream_rdy, istream_msg,
                       acc, cnt, (state == STATE_DONE) ? "D" : "A",
                       ostream_val, ostream_rdy, ostream_msg);
   endfunction

endmodule

// File: tb/tb_lab1_imul_prod_accum.sv
// Directed bench for the product accumulator: p_nprods=4 instance and a p_nprods=1 instance.
module tb_lab1_imul_prod_accum;

   logic        clk;
   logic        reset;

   logic        ival, irdy, oval, ordy;
   logic [31:0] imsg, omsg;

   logic        ival1, irdy1, oval1, ordy1;
   logic [31:0] imsg1, omsg1;

   int checks = 0;
   int errors = 0;

   lab1_imul_prod_accum #(.p_nbits(32), .p_nprods(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .istream_val (ival),
      .istream_rdy (irdy),
      .istream_msg (imsg),
      .ostream_val (oval),
      .ostream_rdy (ordy),
      .ostream_msg (omsg)
   );

   lab1_imul_prod_accum #(.p_nbits(32), .p_nprods(1)) dut1 (
      .clk         (clk),
      .reset       (reset),
      .istream_val (ival1),
      .istream_rdy (irdy1),
      .istream_msg (imsg1),
      .ostream_val (oval1),
      .ostream_rdy (ordy1),
      .ostream_msg (omsg1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then let combinational outputs settle.
   task automatic step(input logic v, input logic [31:0] m, input logic r);
      @(negedge clk);
      ival = v;
      imsg = m;
      ordy = r;
      #1;
   endtask

   task automatic step1(input logic v, input logic [31:0] m, input logic r);
      @(negedge clk);
      ival1 = v;
      imsg1 = m;
      ordy1 = r;
      #1;
   endtask

   initial begin
      logic [31:0] wrap_v [4];
      wrap_v = '{32'hffff_ffff, 32'h2, 32'h0, 32'h0};

      ival = 0; imsg = 0; ordy = 0;
      ival1 = 0; imsg1 = 0; ordy1 = 0;
      reset = 1'b1;
      #2 reset = 1'b0;

      // Reset state
      @(negedge clk); #1;
      check("rst_irdy", 32'(irdy), 32'd0);
      check("rst_oval", 32'(oval), 32'd0);
      check("rst_omsg", omsg, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_irdy", 32'(irdy), 32'd1);

      // Basic group 1,2,3,4
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'(i + 1), 1'b1);
         check("basic_irdy", 32'(irdy), 32'd1);
         check("basic_oval_lo", 32'(oval), 32'd0);
      end
      step(1'b0, 32'h0, 1'b1);
      check("basic_oval", 32'(oval), 32'd1);
      check("basic_sum", omsg, 32'h0000_000a);
      step(1'b0, 32'h0, 1'b1);
      check("basic_oval_once", 32'(oval), 32'd0);

      // Wraparound
      for (int i = 0; i < 4; i++) step(1'b1, wrap_v[i], 1'b1);
      step(1'b0, 32'h0, 1'b1);
      check("wrap_oval", 32'(oval), 32'd1);
      check("wrap_sum", omsg, 32'h0000_0001);

      // Backpressure: 5,5,5,5 then hold the sum while 9 waits
      for (int i = 0; i < 4; i++) step(1'b1, 32'd5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'd9, 1'b0);
         check("bp_oval", 32'(oval), 32'd1);
         check("bp_sum", omsg, 32'h14);
         check("bp_irdy", 32'(irdy), 32'd0);
      end
      step(1'b1, 32'd9, 1'b1);
      check("bp_rel_irdy", 32'(irdy), 32'd1);
      check("bp_rel_oval", 32'(oval), 32'd1);
      check("bp_rel_sum", omsg, 32'h14);
      step(1'b1, 32'd1, 1'b1);
      check("bp_ovl_oval", 32'(oval), 32'd0);
      check("bp_ovl_acc", omsg, 32'd9);
      step(1'b1, 32'd2, 1'b1);
      step(1'b1, 32'd3, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      check("bp_next_oval", 32'(oval), 32'd1);
      check("bp_next_sum", omsg, 32'h0f);

      // Overlap streaming 1..8
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 32'(i + 1), 1'b1);
         check("ovl_irdy", 32'(irdy), 32'd1);
         check("ovl_oval", 32'(oval), 32'(i == 4));
         if (i == 4) check("ovl_sum0", omsg, 32'h0a);
      end
      step(1'b0, 32'h0, 1'b1);
      check("ovl_oval1", 32'(oval), 32'd1);
      check("ovl_sum1", omsg, 32'h1a);

      // Reset mid-group after accepting 5,6
      step(1'b1, 32'd5, 1'b1);
      step(1'b1, 32'd6, 1'b1);
      step(1'b1, 32'd7, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("rstmid_irdy", 32'(irdy), 32'd0);
      check("rstmid_oval", 32'(oval), 32'd0);
      check("rstmid_acc", omsg, 32'h0);
      step(1'b1, 32'd7, 1'b1);
      check("rstmid_hold_irdy", 32'(irdy), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      ival = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 32'd1, 1'b1);
      step(1'b0, 32'h0, 1'b0);
      check("rstmid_oval_after", 32'(oval), 32'd1);
      check("rstmid_sum", omsg, 32'h4);

      // Reset while DONE is pending drops ostream_val and discards the sum
      #2 reset = 1'b0;
      #1;
      check("rstdone_oval", 32'(oval), 32'd0);
      check("rstdone_acc", omsg, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rstdone_irdy", 32'(irdy), 32'd1);

      // p_nprods = 1: each product is its own sum
      step1(1'b1, 32'd7, 1'b1);
      check("n1_irdy0", 32'(irdy1), 32'd1);
      check("n1_oval0", 32'(oval1), 32'd0);
      step1(1'b1, 32'd9, 1'b1);
      check("n1_oval1", 32'(oval1), 32'd1);
      check("n1_sum7", omsg1, 32'd7);
      check("n1_irdy1", 32'(irdy1), 32'd1);
      step1(1'b0, 32'h0, 1'b1);
      check("n1_oval2", 32'(oval1), 32'd1);
      check("n1_sum9", omsg1, 32'd9);
      step1(1'b0, 32'h0, 1'b1);
      check("n1_oval3", 32'(oval1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
